// File: rtl/clk_mon_window_pkg.sv
// Shared types and constants for the clk_mon_window clock-health checker.
//   health_t  : per-channel health classification (2-bit encoding visible on state_out)
//   cfg_sel_t : configuration write target selected by cfg_sel
//   Default*  : reset values of the per-channel window and alarm enable
package clk_mon_window_pkg;

  typedef enum logic [1:0] {
    HealthUnknown = 2'd0,
    HealthGood    = 2'd1,
    HealthBad     = 2'd2,
    HealthLost    = 2'd3
  } health_t;

  typedef enum logic [1:0] {
    CfgMin   = 2'd0,
    CfgMax   = 2'd1,
    CfgClear = 2'd2,
    CfgAen   = 2'd3
  } cfg_sel_t;

  // Wide enough for any supported RATE_W; truncated at the point of use.
  localparam logic [63:0] DefaultMin     = '0;
  localparam logic [63:0] DefaultMax     = '1;
  localparam logic        DefaultAlarmEn = 1'b1;

endpackage

// File: rtl/clk_mon_window_chan.sv
// One monitored channel of clk_mon_window: programmable min/max rate window, in-range
// streak, optional no-measurement timeout, hysteretic health state, saturating fault
// counter and sticky alarm.
//
// Build option: define CLK_MON_WINDOW_TIMEOUT_EN to implement the timeout counter and
// the LOST state; without it LOST is unreachable and TIMEOUT_CYCLES is ignored.
//
// Ports:
//   clk_ref, reset  clock and synchronous active-high reset
//   rate            measured rate for this channel
//   rate_valid      one-cycle strobe marking a new rate
//   locked          synchronised locked status
//   we_min, we_max  threshold write strobes (data on wdata)
//   clear           zero counter/alarm and return to UNKNOWN (thresholds kept)
//   we_aen          alarm enable write strobe (data on wdata[0])
//   wdata           configuration write data
//   state           health state (health_t encoding)
//   fault_count     saturating fault counter
//   alarm           sticky alarm
//   alarm_en        alarm enable register
module clk_mon_window_chan
  import clk_mon_window_pkg::*;
#(
  parameter int unsigned RATE_W         = 32,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned GOOD_COUNT     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
  input  logic              clk_ref,
  input  logic              reset,
  input  logic [RATE_W-1:0] rate,
  input  logic              rate_valid,
  input  logic              locked,
  input  logic              we_min,
  input  logic              we_max,
  input  logic              clear,
  input  logic              we_aen,
  input  logic [RATE_W-1:0] wdata,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  fault_count,
  output logic              alarm,
  output logic              alarm_en
);

  localparam int unsigned        STREAK_W  = $clog2(GOOD_COUNT + 1);
  localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(GOOD_COUNT);

  logic [RATE_W-1:0]   min_q, max_q;
  logic                aen_q;
  logic                locked_q;
  logic [STREAK_W-1:0] streak_q, streak_d;
  health_t             state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                alarm_q, alarm_d;

  logic                in_range, lock_fall, meas_good, meas_bad, range_fault;
  logic                timeout_hit;
  health_t             state_base;
  logic [STREAK_W-1:0] streak_base;
  logic [CNT_W-1:0]    cnt_base;
  logic                alarm_base;

`ifdef CLK_MON_WINDOW_TIMEOUT_EN
  localparam int unsigned  TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] ToMax  = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_q, to_d;

  // Only a GOOD channel can time out; the counter freezes once LOST.
  always_comb begin
    to_d        = to_q;
    timeout_hit = 1'b0;
    if (rate_valid || clear) begin
      to_d = '0;
    end else if (state_q != HealthLost) begin
      if (to_q < ToMax) begin
        to_d = to_q + 1'b1;
      end
      timeout_hit = (state_q == HealthGood) && (to_q >= ToLast);
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    in_range  = (rate >= min_q) && (rate <= max_q);
    lock_fall = locked_q && !locked;

    // A clear in the same cycle is applied first; any event then lands on the cleared values.
    state_base  = clear ? HealthUnknown : state_q;
    streak_base = clear ? '0 : streak_q;
    cnt_base    = clear ? '0 : cnt_q;
    alarm_base  = clear ? 1'b0 : alarm_q;

    meas_good = rate_valid && locked && in_range;
    // An unlocked measurement only faults a channel that is not already BAD.
    meas_bad  = rate_valid && (locked ? !in_range : (state_base != HealthBad));
    range_fault = lock_fall || meas_bad;

    state_d  = state_base;
    streak_d = streak_base;
    cnt_d    = cnt_base;
    alarm_d  = alarm_base;

    if (range_fault || timeout_hit) begin
      cnt_d   = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
      alarm_d = 1'b1;
      if (range_fault) begin
        state_d  = HealthBad;
        streak_d = '0;
      end else begin
        // Streak is kept so the next in-range measurement returns straight to GOOD.
        state_d = HealthLost;
      end
    end else if (meas_good) begin
      if (streak_base != StreakMax) begin
        streak_d = streak_base + 1'b1;
      end
      if (streak_d == StreakMax) begin
        state_d = HealthGood;
      end
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      min_q    <= RATE_W'(DefaultMin);
      max_q    <= RATE_W'(DefaultMax);
      aen_q    <= DefaultAlarmEn;
      locked_q <= 1'b0;
      streak_q <= '0;
      state_q  <= HealthUnknown;
      cnt_q    <= '0;
      alarm_q  <= 1'b0;
    end else begin
      if (we_min) begin
        min_q <= wdata;
      end
      if (we_max) begin
        max_q <= wdata;
      end
      if (we_aen) begin
        aen_q <= wdata[0];
      end
      locked_q <= locked;
      streak_q <= streak_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alarm_q  <= alarm_d;
    end
  end

  assign state       = state_q;
  assign fault_count = cnt_q;
  assign alarm       = alarm_q;
  assign alarm_en    = aen_q;

endmodule

// File: rtl/clk_mon_window.sv
// Multi-channel clock-health checker in the clk_ref domain. Each channel compares its
// measured rate against a programmable window, tracks lock, classifies health and counts
// faults; the top decodes configuration writes and registers the interrupt.
//
// Build option: CLK_MON_WINDOW_TIMEOUT_EN enables the per-channel timeout / LOST state.
//
// Ports:
//   clk_ref, reset  clock and synchronous active-high reset
//   rate_in         NCLK packed rates, channel i at [i*RATE_W +: RATE_W]
//   rate_valid      per-channel new-rate strobe
//   locked          per-channel locked status (already synchronised)
//   cfg_we          configuration write strobe
//   cfg_chan        target channel (>= NCLK ignored)
//   cfg_sel         0 min, 1 max, 2 clear, 3 alarm enable
//   cfg_wdata       configuration write data
//   state_out       NCLK packed 2-bit health states
//   fault_count     NCLK packed saturating fault counters
//   alarm           per-channel sticky alarm
//   irq             registered OR of alarm & alarm_en
module clk_mon_window
  import clk_mon_window_pkg::*;
#(
  parameter int unsigned NCLK           = 4,
  parameter int unsigned RATE_W         = 32,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned GOOD_COUNT     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 200000000,
  parameter int unsigned CHAN_W         = (NCLK > 1) ? $clog2(NCLK) : 1
) (
  input  logic                   clk_ref,
  input  logic                   reset,
  input  logic [NCLK*RATE_W-1:0] rate_in,
  input  logic [NCLK-1:0]        rate_valid,
  input  logic [NCLK-1:0]        locked,
  input  logic                   cfg_we,
  input  logic [CHAN_W-1:0]      cfg_chan,
  input  logic [1:0]             cfg_sel,
  input  logic [RATE_W-1:0]      cfg_wdata,
  output logic [NCLK*2-1:0]      state_out,
  output logic [NCLK*CNT_W-1:0]  fault_count,
  output logic [NCLK-1:0]        alarm,
  output logic                   irq
);

  cfg_sel_t        sel;
  logic [NCLK-1:0] we_min, we_max, clr, we_aen, alarm_en;

  assign sel = cfg_sel_t'(cfg_sel);

  for (genvar i = 0; i < NCLK; i++) begin : g_chan
    logic hit;
    assign hit       = cfg_we && (cfg_chan == CHAN_W'(i));
    assign we_min[i] = hit && (sel == CfgMin);
    assign we_max[i] = hit && (sel == CfgMax);
    assign clr[i]    = hit && (sel == CfgClear);
    assign we_aen[i] = hit && (sel == CfgAen);

    clk_mon_window_chan #(
      .RATE_W        (RATE_W),
      .CNT_W         (CNT_W),
      .GOOD_COUNT    (GOOD_COUNT),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_chan (
      .clk_ref    (clk_ref),
      .reset      (reset),
      .rate       (rate_in[i*RATE_W +: RATE_W]),
      .rate_valid (rate_valid[i]),
      .locked     (locked[i]),
      .we_min     (we_min[i]),
      .we_max     (we_max[i]),
      .clear      (clr[i]),
      .we_aen     (we_aen[i]),
      .wdata      (cfg_wdata),
      .state      (state_out[i*2 +: 2]),
      .fault_count(fault_count[i*CNT_W +: CNT_W]),
      .alarm      (alarm[i]),
      .alarm_en   (alarm_en[i])
    );
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(alarm & alarm_en);
    end
  end

endmodule

// File: doc/clk_mon_window.md
# clk_mon_window

Multi-channel clock-health checker in the `clk_ref` domain, sitting downstream of per-channel `clkRateTool` rate measurements and locked synchronisers.
- Compares each channel's measured rate against a programmable min/max window.
- Tracks locked status and classifies every channel through a hysteretic health state machine.
- Counts faults with saturation, latches sticky alarms and drives one interrupt line.

## Interface
Parameters:
- `NCLK`, 4: number of monitored channels (1..16).
- `RATE_W`, 32: width of rate words and thresholds.
- `CNT_W`, 16: width of the per-channel fault counter.
- `GOOD_COUNT`, 3: consecutive in-range, locked measurements required to declare GOOD (≥1).
- `TIMEOUT_CYCLES`, 200000000: `clk_ref` cycles without `rate_valid` before a channel is declared LOST.
- `CHAN_W`, `max(1,$clog2(NCLK))`: derived, not overridden.

Ports:
- `clk_ref`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `rate_in`  in  `NCLK*RATE_W`  measured rate per channel; channel i occupies `[i*RATE_W +: RATE_W]`.
- `rate_valid`  in  `NCLK`  one-cycle strobe per channel marking a new `rate_in` value.
- `locked`  in  `NCLK`  locked status, already synchronised to `clk_ref`.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_chan`  in  `CHAN_W`  target channel; values ≥`NCLK` are ignored.
- `cfg_sel`  in  2  write target: 0 = min threshold, 1 = max threshold, 2 = clear, 3 = alarm enable (`cfg_wdata[0]`).
- `cfg_wdata`  in  `RATE_W`  write data.
- `state_out`  out  `NCLK*2`  per-channel health state encoding.
- `fault_count`  out  `NCLK*CNT_W`  per-channel saturating fault counter.
- `alarm`  out  `NCLK`  per-channel sticky alarm.
- `irq`  out  1  OR of (`alarm & alarm_en`), registered.

## Operation
- **State encoding:** UNKNOWN = 0, GOOD = 1, BAD = 2, LOST = 3.
- **Reset values:**
  - All states UNKNOWN; counters 0; alarms 0; `irq` 0.
  - min = 0; max = all ones; `alarm_en` = 1.
  - Streak and timeout counters 0.
- **In-range measurement:** `rate_valid` with `min ≤ rate ≤ max` (unsigned, inclusive) and `locked` = 1.
  - Increments a streak counter that saturates at `GOOD_COUNT`.
  - The measurement that brings the streak to `GOOD_COUNT` moves the channel to GOOD.
- **Fault:** an out-of-range measurement, or a falling edge of `locked` (1→0 between consecutive cycles).
  - Channel goes to BAD; streak is cleared.
  - `fault_count` increments and saturates at all ones.
  - `alarm` is set.
- **`locked` = 0 held low:** no further counts; `rate_valid` while unlocked is treated as out-of-range only if it is not already in BAD.
- **Transitions:**
  - UNKNOWN → GOOD or BAD.
  - GOOD → BAD on fault; GOOD → LOST on timeout.
  - BAD → GOOD only after a fresh streak.
  - LOST → BAD/GOOD on the next measurement.
- **LOST entry** also counts as a fault.
- **Clear (`cfg_sel` = 2):** zeroes `fault_count` and `alarm` for the channel and sets state to UNKNOWN; thresholds are kept.
- **min > max:** every measurement is out of range; this is legal, no error.
- **Simultaneous clear and fault on the same channel:** the fault wins after clear. Result: count = 1, `alarm` = 1, state BAD.
- **Threshold write and `rate_valid` in the same cycle:** the comparison uses the old threshold.

## Timing
- `rate_valid` or `locked` edge in cycle t → `state_out`, `fault_count` and `alarm` updated at t+1.
- `irq` at t+2.
- Configuration write in cycle t is visible in the register and in comparisons from t+1.
- Timeout counter:
  - Resets on every `rate_valid` and on clear.
  - LOST asserts in the cycle after `TIMEOUT_CYCLES` consecutive cycles without `rate_valid`.
  - Counter holds while the channel is LOST.
- `reset` mid-operation returns every register to its reset value on the next edge; in-flight strobes in the reset cycle are dropped.

## Configuration
- Macro `CLK_MON_WINDOW_TIMEOUT_EN`.
- **Defined:** per-channel timeout counter and LOST state are implemented as described above.
- **Undefined:** no timeout counter exists, LOST is unreachable, and `TIMEOUT_CYCLES` is ignored; all other behaviour is identical.

## Structure
- **Package `clk_mon_window_pkg`:**
  - `health_t` enum (UNKNOWN/GOOD/BAD/LOST, 2 bits).
  - `cfg_sel_t` enum (MIN/MAX/CLEAR/AEN).
  - Default-threshold constants.
- **Sub-module `clk_mon_window_chan`:** one channel; it holds the thresholds, streak, timeout, state, counter and alarm.
- **Top module:** generates `NCLK` instances, decodes `cfg_we`/`cfg_chan` to per-channel strobes, and registers `irq`.

## Test plan
- Reset, then program ch0 window 99_000_000..101_000_000 and send three valid 100_000_000 rates with `locked` = 1 → ch0 GOOD after the third strobe (+1 cycle); `fault_count` = 0; `irq` = 0.
- With ch1 GOOD, send rate 50_000_000 → ch1 BAD, `fault_count` = 1, `alarm[1]` = 1, `irq` = 1 two cycles after the strobe.
- Drop `locked[2]` for one cycle while GOOD → BAD and count 1. Then clear ch2 in the same cycle as a second `locked` fall → count 1, state BAD.
- Set `alarm_en[3]` = 0, then fault ch3 → `alarm[3]` = 1 and `irq` stays 0. Write `alarm_en` = 1 → `irq` = 1 two cycles later.
- `TIMEOUT_CYCLES` = 10 in the bench, no strobes on ch0 for 10 cycles → LOST on cycle 11 and count incremented. Without the macro, state stays unchanged.
- Force 65_535 faults on ch1, then one more → `fault_count` stays 65_535.
